reg_controller: RTL and testbench



---
 rtl/reg_controller_if.sv | 31 +++
 rtl/reg_controller.sv | 101 ++++++++++
 tb/tb_reg_controller.sv | 329 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/reg_controller_if.sv
// Valid/ready bus interfaces shared by the register controller and its neighbours.
// w_busif carries writes (data+addr); r_busif carries registered reads.
interface w_busif #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned RAM_DEPTH  = 256
);
  localparam int unsigned AW = $clog2(RAM_DEPTH);

  logic [DATA_WIDTH-1:0] data;
  logic [AW-1:0]         addr;
  logic                  valid;
  logic                  ready;

  modport master (output data, output addr, output valid, input ready);
  modport slave  (input data, input addr, input valid, output ready);
endinterface

interface r_busif #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned RAM_DEPTH  = 256
);
  localparam int unsigned AW = $clog2(RAM_DEPTH);

  logic [DATA_WIDTH-1:0] data;
  logic [AW-1:0]         addr;
  logic                  valid;
  logic                  ready;

  modport master (output addr, output valid, input data, input ready);
  modport slave  (input addr, input valid, output data, output ready);
endinterface

// File: rtl/reg_controller.sv
// Shared register file between the host bulk link and fabric logic. Fabric writes are
// mirrored back to the host through a small TX FIFO on bulk_tx.
module reg_controller #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned RAM_DEPTH  = 256,
  parameter int unsigned TX_DEPTH   = 4
) (
  input logic    clk,
  input logic    rstn,
  w_busif.master bulk_tx,
  w_busif.slave  bulk_rx,
  r_busif.slave  r_mem,
  w_busif.slave  w_mem
);
  localparam int unsigned AW = $clog2(RAM_DEPTH);
  localparam int unsigned PW = $clog2(TX_DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [DATA_WIDTH-1:0] mem_q [RAM_DEPTH];

  logic [DATA_WIDTH-1:0] tx_data_q [TX_DEPTH];
  logic [AW-1:0]         tx_addr_q [TX_DEPTH];
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         cnt_q, cnt_d;

  logic [DATA_WIDTH-1:0] rd_data_q;
  logic                  rd_ready_q;

  logic tx_full, tx_empty;
  logic rx_fire, w_fire, tx_pop;

  assign tx_full  = (cnt_q == CW'(TX_DEPTH));
  assign tx_empty = (cnt_q == '0);

  // Host always wins the single write port; fabric waits for both host idle and FIFO room.
  assign bulk_rx.ready = rstn;
  assign w_mem.ready   = rstn && !bulk_rx.valid && !tx_full;

  assign rx_fire = bulk_rx.valid && bulk_rx.ready;
  assign w_fire  = w_mem.valid && w_mem.ready;
  assign tx_pop  = bulk_tx.valid && bulk_tx.ready;

  assign bulk_tx.valid = !tx_empty;
  assign bulk_tx.data  = tx_data_q[rd_ptr_q];
  assign bulk_tx.addr  = tx_addr_q[rd_ptr_q];

  assign r_mem.ready = rd_ready_q;
  assign r_mem.data  = rd_data_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (w_fire) wr_ptr_d = wr_ptr_q + PW'(1);
    if (tx_pop) rd_ptr_d = rd_ptr_q + PW'(1);
    cnt_d = cnt_q + CW'(w_fire) - CW'(tx_pop);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < int'(RAM_DEPTH); i++) mem_q[i] <= '0;
    end else if (rx_fire) begin
      mem_q[bulk_rx.addr] <= bulk_rx.data;
    end else if (w_fire) begin
      mem_q[w_mem.addr] <= w_mem.data;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < int'(TX_DEPTH); i++) begin
        tx_data_q[i] <= '0;
        tx_addr_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (w_fire) begin
        tx_data_q[wr_ptr_q] <= w_mem.data;
        tx_addr_q[wr_ptr_q] <= w_mem.addr;
      end
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Read samples pre-write contents, so a same-edge write shows up one cycle later.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_ready_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      rd_ready_q <= r_mem.valid;
      if (r_mem.valid) rd_data_q <= mem_q[r_mem.addr];
    end
  end

endmodule

// File: tb/tb_reg_controller.sv
// Directed bench for reg_controller: reset, arbitration, reads, FIFO backpressure and
// reset while busy.
module tb_reg_controller;
  localparam int unsigned DW = 32;
  localparam int unsigned RD = 256;

  logic clk;
  logic rstn;

  w_busif #(.DATA_WIDTH(DW), .RAM_DEPTH(RD)) bulk_tx_if ();
  w_busif #(.DATA_WIDTH(DW), .RAM_DEPTH(RD)) bulk_rx_if ();
  r_busif #(.DATA_WIDTH(DW), .RAM_DEPTH(RD)) r_mem_if ();
  w_busif #(.DATA_WIDTH(DW), .RAM_DEPTH(RD)) w_mem_if ();

  reg_controller #(
    .DATA_WIDTH(DW),
    .RAM_DEPTH (RD),
    .TX_DEPTH  (4)
  ) dut (
    .clk    (clk),
    .rstn   (rstn),
    .bulk_tx(bulk_tx_if),
    .bulk_rx(bulk_rx_if),
    .r_mem  (r_mem_if),
    .w_mem  (w_mem_if)
  );

  int checks;
  int failures;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    bulk_tx_if.ready = 1'b1;
    bulk_rx_if.valid = 1'b0;
    bulk_rx_if.data  = '0;
    bulk_rx_if.addr  = '0;
    w_mem_if.valid   = 1'b0;
    w_mem_if.data    = '0;
    w_mem_if.addr    = '0;
    r_mem_if.valid   = 1'b0;
    r_mem_if.addr    = '0;
    repeat (100) step();
    checks++;
    if ({bulk_tx_if.valid, bulk_tx_if.data, bulk_tx_if.addr} !== '0) begin
      failures++;
      $display("FAIL reset_bulk_tx: got v=%b a=%h d=%h, want all 0",
               bulk_tx_if.valid, bulk_tx_if.addr, bulk_tx_if.data);
    end
    checks++;
    if ({r_mem_if.ready, r_mem_if.data} !== '0) begin
      failures++;
      $display("FAIL reset_r_mem: got rdy=%b d=%h, want 0", r_mem_if.ready, r_mem_if.data);
    end
    checks++;
    if ({bulk_rx_if.ready, w_mem_if.ready} !== 2'b00) begin
      failures++;
      $display("FAIL reset_readies: got rx=%b w=%b, want 0 0", bulk_rx_if.ready, w_mem_if.ready);
    end
    rstn = 1'b1;
    step();
    checks++;
    if (bulk_rx_if.ready !== 1'b1) begin
      failures++;
      $display("FAIL rx_ready_after_reset: got %b want 1", bulk_rx_if.ready);
    end
  endtask

  task automatic test_arbitration();
    bulk_rx_if.addr  = 8'hFF;
    bulk_rx_if.data  = 32'h1234_5678;
    bulk_rx_if.valid = 1'b1;
    w_mem_if.addr    = 8'h7F;
    w_mem_if.data    = 32'h1212_1212;
    w_mem_if.valid   = 1'b1;
    #1;
    checks++;
    if (w_mem_if.ready !== 1'b0) begin
      failures++;
      $display("FAIL arb_w_stall: got w.ready=%b want 0", w_mem_if.ready);
    end
    step();
    bulk_rx_if.valid = 1'b0;
    #1;
    checks++;
    if (w_mem_if.ready !== 1'b1 || bulk_tx_if.valid !== 1'b0) begin
      failures++;
      $display("FAIL arb_w_ready: got w.ready=%b tx.valid=%b want 1 0",
               w_mem_if.ready, bulk_tx_if.valid);
    end
    step();
    w_mem_if.valid = 1'b0;
    checks++;
    if (bulk_tx_if.valid !== 1'b1 || bulk_tx_if.addr !== 8'h7F ||
        bulk_tx_if.data !== 32'h1212_1212) begin
      failures++;
      $display("FAIL tx_forward: got v=%b a=%h d=%h want 1 7f 12121212",
               bulk_tx_if.valid, bulk_tx_if.addr, bulk_tx_if.data);
    end
    step();
    checks++;
    if (bulk_tx_if.valid !== 1'b0) begin
      failures++;
      $display("FAIL tx_pop: got valid=%b want 0", bulk_tx_if.valid);
    end
  endtask

  task automatic test_read();
    r_mem_if.addr  = 8'h7F;
    r_mem_if.valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (r_mem_if.ready !== 1'b1 || r_mem_if.data !== 32'h1212_1212) begin
        failures++;
        $display("FAIL read_7f[%0d]: got rdy=%b d=%h want 1 12121212",
                 i, r_mem_if.ready, r_mem_if.data);
      end
    end
    r_mem_if.addr = 8'hFF;
    step();
    checks++;
    if (r_mem_if.data !== 32'h1234_5678) begin
      failures++;
      $display("FAIL read_ff: got %h want 12345678", r_mem_if.data);
    end
    r_mem_if.valid = 1'b0;
    step();
    checks++;
    if (r_mem_if.ready !== 1'b0 || r_mem_if.data !== 32'h1234_5678) begin
      failures++;
      $display("FAIL read_idle_hold: got rdy=%b d=%h want 0 12345678",
               r_mem_if.ready, r_mem_if.data);
    end
  endtask

  task automatic test_same_addr();
    // Read and host write to 0x20 on the same edge: old value first, new value next.
    r_mem_if.addr    = 8'h20;
    r_mem_if.valid   = 1'b1;
    bulk_rx_if.addr  = 8'h20;
    bulk_rx_if.data  = 32'hAAAA_5555;
    bulk_rx_if.valid = 1'b1;
    step();
    bulk_rx_if.valid = 1'b0;
    checks++;
    if (r_mem_if.data !== 32'h0) begin
      failures++;
      $display("FAIL rw_same_edge_old: got %h want 00000000", r_mem_if.data);
    end
    step();
    checks++;
    if (r_mem_if.data !== 32'hAAAA_5555) begin
      failures++;
      $display("FAIL rw_same_edge_new: got %h want aaaa5555", r_mem_if.data);
    end
    r_mem_if.valid = 1'b0;
    // Both writers hit 0x30: fabric value must win since it lands second.
    bulk_rx_if.addr  = 8'h30;
    bulk_rx_if.data  = 32'h1111_1111;
    bulk_rx_if.valid = 1'b1;
    w_mem_if.addr    = 8'h30;
    w_mem_if.data    = 32'h2222_2222;
    w_mem_if.valid   = 1'b1;
    step();
    bulk_rx_if.valid = 1'b0;
    step();
    w_mem_if.valid = 1'b0;
    r_mem_if.addr  = 8'h30;
    r_mem_if.valid = 1'b1;
    step();
    r_mem_if.valid = 1'b0;
    checks++;
    if (r_mem_if.data !== 32'h2222_2222) begin
      failures++;
      $display("FAIL same_addr_priority: got %h want 22222222", r_mem_if.data);
    end
    step();
  endtask

  task automatic test_fifo_full();
    logic [7:0]  exp_a [6];
    logic [31:0] exp_d [6];
    int k;
    int pops;
    bit accept;
    for (int i = 0; i < 6; i++) begin
      exp_a[i] = 8'(8'h40 + i);
      exp_d[i] = 32'hD000_0000 + 32'(i);
    end
    bulk_tx_if.ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      w_mem_if.addr  = exp_a[i];
      w_mem_if.data  = exp_d[i];
      w_mem_if.valid = 1'b1;
      #1;
      checks++;
      if (w_mem_if.ready !== 1'b1) begin
        failures++;
        $display("FAIL fill_ready[%0d]: got %b want 1", i, w_mem_if.ready);
      end
      step();
    end
    w_mem_if.addr = exp_a[4];
    w_mem_if.data = exp_d[4];
    #1;
    checks++;
    if (w_mem_if.ready !== 1'b0 || bulk_tx_if.valid !== 1'b1) begin
      failures++;
      $display("FAIL full_stall: got w.ready=%b tx.valid=%b want 0 1",
               w_mem_if.ready, bulk_tx_if.valid);
    end
    step();
    checks++;
    if (w_mem_if.ready !== 1'b0) begin
      failures++;
      $display("FAIL full_hold: got w.ready=%b want 0", w_mem_if.ready);
    end
    bulk_tx_if.ready = 1'b1;
    k = 4;
    pops = 0;
    for (int cyc = 0; cyc < 40 && pops < 6; cyc++) begin
      #1;
      if (bulk_tx_if.valid === 1'b1) begin
        checks++;
        if (bulk_tx_if.addr !== exp_a[pops] || bulk_tx_if.data !== exp_d[pops]) begin
          failures++;
          $display("FAIL drain_order[%0d]: got a=%h d=%h want a=%h d=%h", pops,
                   bulk_tx_if.addr, bulk_tx_if.data, exp_a[pops], exp_d[pops]);
        end
        pops++;
      end
      accept = w_mem_if.valid && w_mem_if.ready;
      step();
      if (accept) begin
        k++;
        if (k < 6) begin
          w_mem_if.addr = exp_a[k];
          w_mem_if.data = exp_d[k];
        end else begin
          w_mem_if.valid = 1'b0;
        end
      end
    end
    checks++;
    if (pops != 6 || k != 6) begin
      failures++;
      $display("FAIL drain_count: got pops=%0d accepted=%0d want 6 6", pops, k);
    end
    w_mem_if.valid = 1'b0;
    step();
    checks++;
    if (bulk_tx_if.valid !== 1'b0) begin
      failures++;
      $display("FAIL drain_empty: got valid=%b want 0", bulk_tx_if.valid);
    end
  endtask

  task automatic test_reset_mid();
    bulk_tx_if.ready = 1'b0;
    w_mem_if.addr    = 8'h55;
    w_mem_if.data    = 32'hCAFE_F00D;
    w_mem_if.valid   = 1'b1;
    r_mem_if.addr    = 8'h7F;
    r_mem_if.valid   = 1'b1;
    step();
    step();
    w_mem_if.valid = 1'b0;
    checks++;
    if (bulk_tx_if.valid !== 1'b1 || r_mem_if.ready !== 1'b1) begin
      failures++;
      $display("FAIL busy_before_reset: got tx.valid=%b r.ready=%b want 1 1",
               bulk_tx_if.valid, r_mem_if.ready);
    end
    #2;
    rstn = 1'b0;
    #1;
    checks++;
    if (bulk_tx_if.valid !== 1'b0 || r_mem_if.ready !== 1'b0 || r_mem_if.data !== '0) begin
      failures++;
      $display("FAIL async_reset: got tx.valid=%b r.ready=%b r.data=%h want 0 0 0",
               bulk_tx_if.valid, r_mem_if.ready, r_mem_if.data);
    end
    r_mem_if.valid = 1'b0;
    step();
    step();
    rstn = 1'b1;
    bulk_tx_if.ready = 1'b1;
    r_mem_if.addr  = 8'h7F;
    r_mem_if.valid = 1'b1;
    step();
    checks++;
    if (r_mem_if.ready !== 1'b1 || r_mem_if.data !== 32'h0) begin
      failures++;
      $display("FAIL mem_cleared_7f: got rdy=%b d=%h want 1 00000000",
               r_mem_if.ready, r_mem_if.data);
    end
    r_mem_if.addr = 8'h10;
    step();
    r_mem_if.valid = 1'b0;
    checks++;
    if (r_mem_if.data !== 32'h0 || bulk_tx_if.valid !== 1'b0) begin
      failures++;
      $display("FAIL unwritten_10: got d=%h tx.valid=%b want 00000000 0",
               r_mem_if.data, bulk_tx_if.valid);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_arbitration();
    test_read();
    test_same_addr();
    test_fifo_full();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
